// File: rtl/priv_trap_ctrl.sv
// priv_trap_ctrl: sequences every privilege transition of the hart.
// Traps (exception/interrupt) and xRET are arbitrated in IDLE, the pipeline is
// flushed, privilege and trap CSRs are committed in a single cycle, then the PC
// redirect is issued. This block is the only writer of the privilege register.
// Optional feature macro: PRIV_SMODE_EN (supervisor mode, trap delegation, SRET).
module priv_trap_ctrl #(
   parameter int XLEN    = 32,
   parameter int CAUSE_W = 5
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [1:0]         priv_rval,
   output logic               priv_w_en,
   output logic [1:0]         priv_w_val,
   input  logic               exc_valid,
   input  logic [CAUSE_W-1:0] exc_cause,
   input  logic [XLEN-1:0]    exc_pc,
   input  logic [XLEN-1:0]    exc_tval,
   input  logic               irq_valid,
   input  logic [CAUSE_W-1:0] irq_cause,
   input  logic [XLEN-1:0]    irq_pc,
   input  logic               mret_valid,
   input  logic               sret_valid,
   output logic               req_ready,
   input  logic [XLEN-1:0]    mstatus_in,
   input  logic [XLEN-1:0]    medeleg,
   input  logic [XLEN-1:0]    mideleg,
   input  logic [XLEN-1:0]    mtvec,
   input  logic [XLEN-1:0]    stvec,
   input  logic [XLEN-1:0]    mepc,
   input  logic [XLEN-1:0]    sepc,
   output logic               flush_req,
   input  logic               flush_ack,
   output logic               csr_we,
   output logic [1:0]         csr_tgt,
   output logic [XLEN-1:0]    csr_epc,
   output logic [XLEN-1:0]    csr_tval,
   output logic [XLEN-1:0]    csr_cause,
   output logic [XLEN-1:0]    csr_mstatus,
   output logic               csr_trap,
   output logic               redirect_valid,
   output logic [XLEN-1:0]    redirect_pc,
   input  logic               redirect_ready
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_COMMIT   = 2'd2,
      ST_REDIRECT = 2'd3
   } state_t;

   localparam logic [1:0] KIND_EXC  = 2'd0;
   localparam logic [1:0] KIND_IRQ  = 2'd1;
   localparam logic [1:0] KIND_MRET = 2'd2;
   localparam logic [1:0] KIND_SRET = 2'd3;

   localparam logic [1:0] PRIV_U = 2'b00;
   localparam logic [1:0] PRIV_S = 2'b01;
   localparam logic [1:0] PRIV_M = 2'b11;

   // mstatus field positions
   localparam int SIE_B  = 1;
   localparam int MIE_B  = 3;
   localparam int SPIE_B = 5;
   localparam int MPIE_B = 7;
   localparam int SPP_B  = 8;
   localparam int MPP_LO = 11;
   localparam int MPP_HI = 12;

   state_t               state_reg, state_next;
   logic [1:0]           kind_reg;
   logic [CAUSE_W-1:0]   cause_reg;
   logic [XLEN-1:0]      pc_reg;
   logic [XLEN-1:0]      tval_reg;
   logic [1:0]           priv_reg;
   logic [XLEN-1:0]      redirect_pc_reg;

   // acceptance path
   logic                 irq_ok;
   logic                 accept;
   logic [1:0]           acc_kind;
   logic [CAUSE_W-1:0]   acc_cause;
   logic [XLEN-1:0]      acc_pc;
   logic [XLEN-1:0]      acc_tval;

   // commit path
   logic                 trap_c;
   logic                 intr_c;
   logic                 to_s_c;
   logic [CAUSE_W-1:0]   code_c;
   logic [XLEN-1:0]      tval_c;
   logic [1:0]           tgt_c;
   logic [1:0]           new_priv_c;
   logic [XLEN-1:0]      mstatus_c;
   logic [XLEN-1:0]      redir_c;

`ifdef PRIV_SMODE_EN
   logic [XLEN-1:0]      deleg_mask;
   logic [XLEN-1:0]      deleg_sh;
`else
   // Delegation and supervisor CSRs have no effect without S-mode.
   logic                 unused_smode_inputs;
   assign unused_smode_inputs = ^{medeleg, mideleg, stvec, sepc};
`endif

   // Interrupts are taken below M regardless of MIE; at M only when MIE is set.
   assign irq_ok = irq_valid && ((priv_rval != PRIV_M) || mstatus_in[MIE_B]);

   // Fixed-priority request selection: exc > irq > mret > sret.
   // xRET has no dedicated PC bus; the retiring instruction's PC arrives on exc_pc.
   always_comb begin
      accept    = 1'b0;
      acc_kind  = KIND_EXC;
      acc_cause = exc_cause;
      acc_pc    = exc_pc;
      acc_tval  = exc_tval;
      if (exc_valid) begin
         accept = 1'b1;
      end else if (irq_ok) begin
         accept    = 1'b1;
         acc_kind  = KIND_IRQ;
         acc_cause = irq_cause;
         acc_pc    = irq_pc;
         acc_tval  = '0;
      end else if (mret_valid) begin
         accept    = 1'b1;
         acc_kind  = KIND_MRET;
         acc_cause = '0;
         acc_tval  = '0;
      end else if (sret_valid) begin
         accept    = 1'b1;
         acc_kind  = KIND_SRET;
         acc_cause = '0;
         acc_tval  = '0;
      end
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_reg <= ST_IDLE;
      else          state_reg <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE:     if (accept)         state_next = ST_FLUSH;
         ST_FLUSH:    if (flush_ack)      state_next = ST_COMMIT;
         ST_COMMIT:                       state_next = ST_REDIRECT;
         ST_REDIRECT: if (redirect_ready) state_next = ST_IDLE;
         default:                         state_next = ST_IDLE;
      endcase
   end

   // Latch the accepted request; capture the redirect target during commit.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         kind_reg        <= KIND_EXC;
         cause_reg       <= '0;
         pc_reg          <= '0;
         tval_reg        <= '0;
         priv_reg        <= PRIV_U;
         redirect_pc_reg <= '0;
      end else begin
         if (state_reg == ST_IDLE && accept) begin
            kind_reg  <= acc_kind;
            cause_reg <= acc_cause;
            pc_reg    <= acc_pc;
            tval_reg  <= acc_tval;
            priv_reg  <= priv_rval;
         end
         if (state_reg == ST_COMMIT) redirect_pc_reg <= redir_c;
      end
   end

   // Commit values: legal xRET restores state, anything else is a trap
   // (an xRET at insufficient privilege becomes illegal-instruction, cause 2).
   always_comb begin
      trap_c     = 1'b1;
      intr_c     = (kind_reg == KIND_IRQ);
      to_s_c     = 1'b0;
      code_c     = cause_reg;
      tval_c     = tval_reg;
      tgt_c      = PRIV_M;
      new_priv_c = PRIV_M;
      mstatus_c  = mstatus_in;
      redir_c    = {mtvec[XLEN-1:2], 2'b00};
`ifdef PRIV_SMODE_EN
      deleg_mask = '0;
      deleg_sh   = '0;
`endif
      if (kind_reg == KIND_MRET && priv_reg == PRIV_M) begin
         trap_c                    = 1'b0;
         new_priv_c                = mstatus_in[MPP_HI:MPP_LO];
         mstatus_c[MIE_B]          = mstatus_in[MPIE_B];
         mstatus_c[MPIE_B]         = 1'b1;
         mstatus_c[MPP_HI:MPP_LO]  = PRIV_U;
         redir_c                   = mepc;
`ifdef PRIV_SMODE_EN
      end else if (kind_reg == KIND_SRET && priv_reg != PRIV_U) begin
         trap_c            = 1'b0;
         tgt_c             = PRIV_S;
         new_priv_c        = {1'b0, mstatus_in[SPP_B]};
         mstatus_c[SIE_B]  = mstatus_in[SPIE_B];
         mstatus_c[SPIE_B] = 1'b1;
         mstatus_c[SPP_B]  = 1'b0;
         redir_c           = sepc;
`endif
      end else begin
         if (kind_reg == KIND_MRET || kind_reg == KIND_SRET) begin
            code_c = CAUSE_W'(2);
            tval_c = '0;
            intr_c = 1'b0;
         end
`ifdef PRIV_SMODE_EN
         deleg_mask = intr_c ? mideleg : medeleg;
         deleg_sh   = deleg_mask >> code_c;
         to_s_c     = !priv_reg[1] && deleg_sh[0];
`endif
         if (to_s_c) begin
            tgt_c             = PRIV_S;
            new_priv_c        = PRIV_S;
            mstatus_c[SPIE_B] = mstatus_in[SIE_B];
            mstatus_c[SIE_B]  = 1'b0;
            mstatus_c[SPP_B]  = priv_reg[0];
            redir_c           = {stvec[XLEN-1:2], 2'b00};
         end else begin
            mstatus_c[MPIE_B]         = mstatus_in[MIE_B];
            mstatus_c[MIE_B]          = 1'b0;
            mstatus_c[MPP_HI:MPP_LO]  = priv_reg;
         end
      end
   end

   // Outputs decoded from state; commit values are only driven during COMMIT.
   always_comb begin
      req_ready      = (state_reg == ST_IDLE);
      flush_req      = (state_reg == ST_FLUSH);
      priv_w_en      = 1'b0;
      priv_w_val     = PRIV_U;
      csr_we         = 1'b0;
      csr_tgt        = 2'b00;
      csr_trap       = 1'b0;
      csr_epc        = '0;
      csr_tval       = '0;
      csr_cause      = '0;
      csr_mstatus    = '0;
      redirect_valid = (state_reg == ST_REDIRECT);
      redirect_pc    = '0;
      if (state_reg == ST_COMMIT) begin
         priv_w_en   = 1'b1;
         priv_w_val  = new_priv_c;
         csr_we      = 1'b1;
         csr_tgt     = tgt_c;
         csr_trap    = trap_c;
         csr_mstatus = mstatus_c;
         if (trap_c) begin
            csr_epc   = pc_reg;
            csr_tval  = tval_c;
            csr_cause = {intr_c, {(XLEN-1-CAUSE_W){1'b0}}, code_c};
         end
      end
      if (state_reg == ST_REDIRECT) redirect_pc = redirect_pc_reg;
   end

endmodule

// File: tb/tb_priv_trap_ctrl.sv
module tb_priv_trap_ctrl;
    localparam int XLEN    = 32;
    localparam int CAUSE_W = 5;

    logic               clock = 1'b0;
    logic               reset_n;
    logic [1:0]         priv_rval;
    logic               priv_w_en;
    logic [1:0]         priv_w_val;
    logic               exc_valid;
    logic [CAUSE_W-1:0] exc_cause;
    logic [XLEN-1:0]    exc_pc, exc_tval;
    logic               irq_valid;
    logic [CAUSE_W-1:0] irq_cause;
    logic [XLEN-1:0]    irq_pc;
    logic               mret_valid, sret_valid, req_ready;
    logic [XLEN-1:0]    mstatus_in, medeleg, mideleg, mtvec, stvec, mepc, sepc;
    logic               flush_req, flush_ack, csr_we, csr_trap;
    logic [1:0]         csr_tgt;
    logic [XLEN-1:0]    csr_epc, csr_tval, csr_cause, csr_mstatus;
    logic               redirect_valid, redirect_ready;
    logic [XLEN-1:0]    redirect_pc;

    priv_trap_ctrl #(.XLEN(XLEN), .CAUSE_W(CAUSE_W)) dut (
        .clock(clock), .reset_n(reset_n), .priv_rval(priv_rval),
        .priv_w_en(priv_w_en), .priv_w_val(priv_w_val),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .irq_valid(irq_valid), .irq_cause(irq_cause), .irq_pc(irq_pc),
        .mret_valid(mret_valid), .sret_valid(sret_valid), .req_ready(req_ready),
        .mstatus_in(mstatus_in), .medeleg(medeleg), .mideleg(mideleg),
        .mtvec(mtvec), .stvec(stvec), .mepc(mepc), .sepc(sepc),
        .flush_req(flush_req), .flush_ack(flush_ack),
        .csr_we(csr_we), .csr_tgt(csr_tgt), .csr_epc(csr_epc), .csr_tval(csr_tval),
        .csr_cause(csr_cause), .csr_mstatus(csr_mstatus), .csr_trap(csr_trap),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  pv;
        logic [1:0]  tgt;
        logic        trap;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] tval;
        logic [31:0] mst;
        logic [31:0] redir;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   txn_no = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic report(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        fails++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push(input logic [1:0] pv, input logic [1:0] tgt, input logic trap,
                        input logic [31:0] cause, input logic [31:0] epc,
                        input logic [31:0] tval, input logic [31:0] mst,
                        input logic [31:0] redir);
        exp_t e;
        e.pv = pv; e.tgt = tgt; e.trap = trap; e.cause = cause;
        e.epc = epc; e.tval = tval; e.mst = mst; e.redir = redir;
        sb_q.push_back(e);
    endtask

    task automatic accept();
        tests++;
        if (req_ready !== 1'b1) report("req_ready_idle", req_ready, 1'b1);
        tick();
    endtask

    task automatic run_txn(input int ack_delay, input int rdy_delay);
        exp_t e;
        int   waited;
        tests++;
        if (req_ready !== 1'b0) report("req_ready_busy", req_ready, 1'b0);
        tests++;
        if (flush_req !== 1'b1) report("flush_req", flush_req, 1'b1);
        for (int i = 0; i < ack_delay; i++) begin
            tests++;
            if (priv_w_en !== 1'b0) report("no_early_commit", priv_w_en, 1'b0);
            tick();
            tests++;
            if (flush_req !== 1'b1) report("flush_hold", flush_req, 1'b1);
        end
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        waited = 0;
        while (!csr_we && waited < 8) begin
            tick();
            waited++;
        end
        tests++;
        if (waited != 0) report("commit_latency", waited, 0);
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL sb_empty: observed=commit expected=no_commit");
        end else begin
            e = sb_q.pop_front();
            tests++;
            if (priv_w_en !== 1'b1) report("priv_w_en", priv_w_en, 1'b1);
            tests++;
            if (priv_w_val !== e.pv) report("priv_w_val", priv_w_val, e.pv);
            tests++;
            if (csr_tgt !== e.tgt) report("csr_tgt", csr_tgt, e.tgt);
            tests++;
            if (csr_trap !== e.trap) report("csr_trap", csr_trap, e.trap);
            tests++;
            if (csr_mstatus !== e.mst) report("csr_mstatus", csr_mstatus, e.mst);
            if (e.trap) begin
                tests++;
                if (csr_cause !== e.cause) report("csr_cause", csr_cause, e.cause);
                tests++;
                if (csr_epc !== e.epc) report("csr_epc", csr_epc, e.epc);
                tests++;
                if (csr_tval !== e.tval) report("csr_tval", csr_tval, e.tval);
            end
            tick();
            tests++;
            if (priv_w_en !== 1'b0) report("commit_one_cycle", priv_w_en, 1'b0);
            tests++;
            if (redirect_valid !== 1'b1) report("redirect_valid", redirect_valid, 1'b1);
            tests++;
            if (redirect_pc !== e.redir) report("redirect_pc", redirect_pc, e.redir);
            for (int i = 0; i < rdy_delay; i++) begin
                tick();
                tests++;
                if (redirect_valid !== 1'b1) report("redirect_hold", redirect_valid, 1'b1);
                tests++;
                if (redirect_pc !== e.redir) report("redirect_pc_stable", redirect_pc, e.redir);
            end
            redirect_ready = 1'b1;
            tick();
            redirect_ready = 1'b0;
            tests++;
            if (redirect_valid !== 1'b0) report("redirect_drop", redirect_valid, 1'b0);
            tests++;
            if (req_ready !== 1'b1) report("back_idle", req_ready, 1'b1);
            txn_no++;
            $display("[TB] txn %0d: priv=%0h tgt=%0h trap=%0b cause=%0h epc=%0h mstatus=%0h redirect=%0h",
                     txn_no, e.pv, e.tgt, e.trap, e.cause, e.epc, e.mst, e.redir);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        priv_rval = 2'b11;
        exc_valid = 0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
        irq_valid = 0; irq_cause = '0; irq_pc = '0;
        mret_valid = 0; sret_valid = 0;
        mstatus_in = '0; medeleg = '0; mideleg = '0;
        mtvec = 32'h8000_0001; stvec = 32'h9000_0002; mepc = 32'h1234; sepc = 32'h5678;
        flush_ack = 0; redirect_ready = 0;
        tick(); tick();
        tests++;
        if (req_ready !== 1'b1) report("rst_req_ready", req_ready, 1'b1);
        tests++;
        if (priv_w_en !== 1'b0) report("rst_priv_w_en", priv_w_en, 1'b0);
        tests++;
        if (flush_req !== 1'b0) report("rst_flush_req", flush_req, 1'b0);
        tests++;
        if (csr_we !== 1'b0) report("rst_csr_we", csr_we, 1'b0);
        tests++;
        if (redirect_valid !== 1'b0) report("rst_redirect_valid", redirect_valid, 1'b0);
        tests++;
        if (redirect_pc !== 32'h0) report("rst_redirect_pc", redirect_pc, 32'h0);
        reset_n = 1'b1;
        tick();

        priv_rval = 2'b11; mstatus_in = 32'h00A0_0088;
        exc_cause = 5'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
        push(2'b11, 2'b11, 1'b1, 32'h2, 32'h100, 32'hDEAD, 32'h00A0_1880, 32'h8000_0000);
        exc_valid = 1;
        accept();
        exc_valid = 0;
        run_txn(0, 0);

        mstatus_in = 32'h8;
        exc_cause = 5'd5; exc_pc = 32'h200; exc_tval = 32'h44;
        irq_cause = 5'd7; irq_pc = 32'h300;
        push(2'b11, 2'b11, 1'b1, 32'h5, 32'h200, 32'h44, 32'h1880, 32'h8000_0000);
        push(2'b11, 2'b11, 1'b1, 32'h8000_0007, 32'h300, 32'h0, 32'h1880, 32'h8000_0000);
        exc_valid = 1; irq_valid = 1; mret_valid = 1;
        accept();
        exc_valid = 0; mret_valid = 0;
        run_txn(0, 0);
        accept();
        irq_valid = 0;
        run_txn(0, 0);

        priv_rval = 2'b00; mstatus_in = 32'h80;
        exc_pc = 32'h400; exc_tval = 32'h77;
        push(2'b11, 2'b11, 1'b1, 32'h2, 32'h400, 32'h0, 32'h0, 32'h8000_0000);
        mret_valid = 1;
        accept();
        mret_valid = 0;
        run_txn(0, 0);

        priv_rval = 2'b11; mstatus_in = 32'h80;
        push(2'b00, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 32'h88, 32'h1234);
        mret_valid = 1;
        accept();
        mret_valid = 0;
        run_txn(0, 0);

        mstatus_in = 32'h0; irq_cause = 5'd3; irq_pc = 32'h600;
        irq_valid = 1;
        tick(); tick();
        tests++;
        if (flush_req !== 1'b0) report("irq_masked_no_flush", flush_req, 1'b0);
        tests++;
        if (req_ready !== 1'b1) report("irq_masked_idle", req_ready, 1'b1);
        priv_rval = 2'b00;
        push(2'b11, 2'b11, 1'b1, 32'h8000_0003, 32'h600, 32'h0, 32'h0, 32'h8000_0000);
        accept();
        irq_valid = 0;
        run_txn(5, 3);

        priv_rval = 2'b00; mstatus_in = 32'h2; medeleg = 32'h100;
        exc_cause = 5'd8; exc_pc = 32'h500; exc_tval = 32'h0;
`ifdef PRIV_SMODE_EN
        push(2'b01, 2'b01, 1'b1, 32'h8, 32'h500, 32'h0, 32'h20, 32'h9000_0000);
`else
        push(2'b11, 2'b11, 1'b1, 32'h8, 32'h500, 32'h0, 32'h2, 32'h8000_0000);
`endif
        exc_valid = 1;
        accept();
        exc_valid = 0;
        run_txn(0, 0);
        medeleg = '0;

        priv_rval = 2'b11; mstatus_in = 32'h120; exc_pc = 32'h700;
`ifdef PRIV_SMODE_EN
        push(2'b01, 2'b01, 1'b0, 32'h0, 32'h0, 32'h0, 32'h22, 32'h5678);
`else
        push(2'b11, 2'b11, 1'b1, 32'h2, 32'h700, 32'h0, 32'h1920, 32'h8000_0000);
`endif
        sret_valid = 1;
        accept();
        sret_valid = 0;
        run_txn(0, 0);

        exc_cause = 5'd4; exc_pc = 32'h800;
        exc_valid = 1;
        accept();
        exc_valid = 0;
        tick();
        tests++;
        if (flush_req !== 1'b1) report("pre_rst_flush", flush_req, 1'b1);
        reset_n = 1'b0;
        #1;
        tests++;
        if (flush_req !== 1'b0) report("midrst_flush_req", flush_req, 1'b0);
        tests++;
        if (req_ready !== 1'b1) report("midrst_req_ready", req_ready, 1'b1);
        flush_ack = 1'b1;
        tick();
        tests++;
        if (priv_w_en !== 1'b0) report("midrst_priv_w_en", priv_w_en, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();
        tests++;
        if (priv_w_en !== 1'b0) report("postrst_priv_w_en", priv_w_en, 1'b0);
        tests++;
        if (csr_we !== 1'b0) report("postrst_csr_we", csr_we, 1'b0);
        tests++;
        if (flush_req !== 1'b0) report("postrst_flush_req", flush_req, 1'b0);
        flush_ack = 1'b0;
        tick();

        tests++;
        if (sb_q.size() != 0) report("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
